// File: rtl/umi_pkg.sv
// Shared UMI register-slave types: FSM states, captured request, address map, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package umi_pkg;

    localparam int UMI_AW = 18;
    localparam int UMI_DW = 36;

    localparam logic [UMI_AW-1:0] ADDR_ID       = 18'h00;
    localparam logic [UMI_AW-1:0] ADDR_STAT     = 18'h01;
    localparam logic [UMI_AW-1:0] ADDR_CFG_BASE = 18'h10;
    localparam logic [UMI_AW-1:0] ADDR_CFG_TOP  = 18'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_DONE
    } umi_state_t;

    typedef struct packed {
        logic [UMI_AW-1:0] addr;
        logic [7:0]        wdata;
        logic              wr_n;
        logic [7:0]        stat;
        logic              busy;
    } umi_req_t;

    // Read responses replicate the byte across all four lanes.
    function automatic logic [UMI_DW-1:0] rep4(input logic [7:0] b);
        return {4'b0, b, b, b, b};
    endfunction

endpackage

// File: rtl/umi_reg_bank.sv
// Config register storage and address decode; UMI_REG_SLAVE_RO_PROTECT_EN makes writes to 0x00-0x0F errors.
// Latency: decode combinational, write commits on the clock edge ending the commit cycle.
// Backpressure: none; busy requests are reported as retry and never written.
module umi_reg_bank
    import umi_pkg::*;
#(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic           clk,
    input  logic           rstn,
    input  umi_req_t       dec_req,
    input  logic           commit,
    output logic [7:0]     rd_byte,
    output logic           err,
    output logic           retry,
    output logic [127:0]   cfg_out
);

    logic [15:0][7:0] cfg_q;
    logic             in_range;
    logic             is_cfg;
    logic             wr_ok;

    assign in_range = (dec_req.addr <= ADDR_CFG_TOP);
    assign is_cfg   = in_range && (dec_req.addr >= ADDR_CFG_BASE);

`ifdef UMI_REG_SLAVE_RO_PROTECT_EN
    assign err = !in_range || (dec_req.wr_n && !is_cfg);
`else
    assign err = !in_range;
`endif

    assign retry = dec_req.busy && !err;
    assign wr_ok = dec_req.wr_n && is_cfg && !err && !retry;

    always_comb begin
        rd_byte = 8'h00;
        if (dec_req.addr == ADDR_ID) begin
            rd_byte = ID_VALUE;
        end else if (dec_req.addr == ADDR_STAT) begin
            rd_byte = dec_req.stat;
        end else if (is_cfg) begin
            rd_byte = cfg_q[dec_req.addr[3:0]];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_q <= '0;
        end else if (commit && wr_ok) begin
            cfg_q[dec_req.addr[3:0]] <= dec_req.wdata;
        end
    end

    assign cfg_out = cfg_q;

endmodule

// File: rtl/umi_reg_slave.sv
// UMI register slave: request capture, wait states, one-cycle ack; UMI_REG_SLAVE_RO_PROTECT_EN errors writes to 0x00-0x0F.
// Latency: ack WAIT_CYCLES+1 cycles after capture; dropping umi_req before ack aborts silently.
// Backpressure: umi_rdy is not required; a new request needs umi_req low for a cycle after the ack.
module umi_reg_slave
    import umi_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              umi_req,
    input  logic [UMI_AW-1:0] umi_addr,
    input  logic [UMI_DW-1:0] umi_wdata,
    input  logic              umi_wr_n,
    input  logic              umi_rdy,
    output logic [UMI_DW-1:0] umi_rdata,
    output logic              umi_ack,
    output logic              umi_retry,
    output logic              umi_err,
    input  logic [7:0]        stat_in,
    input  logic              busy_in,
    output logic [127:0]      cfg_out
);

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    umi_state_t        state_q, state_nxt;
    logic [3:0]        wait_cnt_q;
    umi_req_t          req_q, live_req, dec_req;
    logic              rsp_err_q, rsp_retry_q;
    logic [UMI_DW-1:0] rdata_q;
    logic [7:0]        rd_byte;
    logic              dec_err, dec_retry;
    logic              capture;
    logic              unused_ok;

    assign unused_ok = ^{umi_rdy, umi_wdata[UMI_DW-1:8]};

    assign live_req = '{addr: umi_addr, wdata: umi_wdata[7:0], wr_n: umi_wr_n,
                        stat: stat_in, busy: busy_in};

    // Decode the live request while idle so the response can be latched at capture.
    assign dec_req = (state_q == ST_IDLE) ? live_req : req_q;
    assign capture = (state_q == ST_IDLE) && umi_req;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (umi_req) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!umi_req) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!umi_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q <= state_nxt;
            if (capture) begin
                wait_cnt_q <= 4'd0;
            end else if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q       <= '0;
            rsp_err_q   <= 1'b0;
            rsp_retry_q <= 1'b0;
            rdata_q     <= '0;
        end else if (capture) begin
            req_q       <= live_req;
            rsp_err_q   <= dec_err;
            rsp_retry_q <= dec_retry;
            rdata_q     <= (dec_err || dec_retry || umi_wr_n) ? '0 : rep4(rd_byte);
        end
    end

    umi_reg_bank #(
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk     (clk),
        .rstn    (rstn),
        .dec_req (dec_req),
        .commit  (state_q == ST_ACK),
        .rd_byte (rd_byte),
        .err     (dec_err),
        .retry   (dec_retry),
        .cfg_out (cfg_out)
    );

    assign umi_ack   = (state_q == ST_ACK);
    assign umi_err   = umi_ack && rsp_err_q;
    assign umi_retry = umi_ack && rsp_retry_q;
    assign umi_rdata = rdata_q;

endmodule

// File: tb/tb_umi_reg_slave.sv
// Directed and randomized checks of umi_reg_slave against a register-map model.
module tb_umi_reg_slave;

`ifdef UMI_REG_SLAVE_RO_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    localparam int WAIT = 2;

    logic         clk = 1'b0;
    logic         rstn;
    logic         umi_req;
    logic [17:0]  umi_addr;
    logic [35:0]  umi_wdata;
    logic         umi_wr_n;
    logic         umi_rdy;
    logic [35:0]  umi_rdata;
    logic         umi_ack;
    logic         umi_retry;
    logic         umi_err;
    logic [7:0]   stat_in;
    logic         busy_in;
    logic [127:0] cfg_out;

    int checks = 0;
    int failures = 0;
    logic [7:0]  mem [16];
    logic [35:0] last_rd;
    logic        last_err, last_rt;

    umi_reg_slave #(.ID_VALUE(8'hA5), .WAIT_CYCLES(WAIT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .umi_req   (umi_req),
        .umi_addr  (umi_addr),
        .umi_wdata (umi_wdata),
        .umi_wr_n  (umi_wr_n),
        .umi_rdy   (umi_rdy),
        .umi_rdata (umi_rdata),
        .umi_ack   (umi_ack),
        .umi_retry (umi_retry),
        .umi_err   (umi_err),
        .stat_in   (stat_in),
        .busy_in   (busy_in),
        .cfg_out   (cfg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_cfg();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = mem[k];
        return r;
    endfunction

    task automatic run_txn(input logic [17:0] a, input logic [7:0] wd, input bit wr,
                           input logic [7:0] st, input bit bz, output bit acked, output int lat,
                           output logic [35:0] rd, output logic er, output logic rt);
        logic [27:0] hi;
        hi = 28'($urandom);
        @(negedge clk);
        umi_req = 1'b1; umi_addr = a; umi_wdata = {hi, wd}; umi_wr_n = wr;
        stat_in = st; busy_in = bz;
        acked = 1'b0; lat = 0; rd = '0; er = 1'b0; rt = 1'b0;
        for (int i = 1; i <= 40 && !acked; i++) begin
            @(negedge clk);
            if (i == 1) begin
                stat_in = 8'($urandom);
                busy_in = 1'($urandom);
            end
            if (umi_ack) begin
                acked = 1'b1; lat = i; rd = umi_rdata; er = umi_err; rt = umi_retry;
            end
        end
        umi_req = 1'b0;
        umi_rdy = acked;
        @(negedge clk);
        umi_rdy = 1'b0;
        chk("ack_one_cycle", 128'(umi_ack), 128'(0));
        chk("qual_without_ack", 128'({umi_err, umi_retry}), 128'(0));
        chk("rdata_hold", 128'(umi_rdata), 128'(rd));
    endtask

    task automatic txn(input logic [17:0] a, input logic [7:0] wd, input bit wr,
                       input logic [7:0] st, input bit bz);
        logic        exp_err, exp_rt;
        logic [7:0]  b;
        logic [35:0] exp_rd, rd;
        bit          acked;
        int          lat;
        logic        er, rt;
        exp_err = (a > 18'h1F) || (PROT && wr && a < 18'h10);
        exp_rt  = !exp_err && bz;
        if (a == 0) b = 8'hA5;
        else if (a == 1) b = st;
        else if (a < 18'h10) b = 8'h00;
        else if (a < 18'h20) b = mem[a[3:0]];
        else b = 8'h00;
        exp_rd = (exp_err || exp_rt || wr) ? 36'h0 : {4'h0, b, b, b, b};
        run_txn(a, wd, wr, st, bz, acked, lat, rd, er, rt);
        if (wr && !exp_err && !exp_rt && a >= 18'h10) mem[a[3:0]] = wd;
        chk("ack_seen", 128'(acked), 128'(1));
        chk("ack_latency", 128'(lat), 128'(WAIT + 1));
        chk("rdata", 128'(rd), 128'(exp_rd));
        chk("err", 128'(er), 128'(exp_err));
        chk("retry", 128'(rt), 128'(exp_rt));
        chk("cfg_out", cfg_out, model_cfg());
        last_rd = rd; last_err = er; last_rt = rt;
    endtask

    initial begin
        int ack_cnt;
        logic [17:0] ra;
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        rstn = 1'b0; umi_req = 1'b0; umi_addr = '0; umi_wdata = '0; umi_wr_n = 1'b0;
        umi_rdy = 1'b0; stat_in = 8'h00; busy_in = 1'b0;
        #12;
        chk("reset_outputs", 128'({umi_ack, umi_err, umi_retry, umi_rdata}), 128'(0));
        chk("reset_cfg", cfg_out, 128'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Write then read back a config register.
        txn(18'h10, 8'h3C, 1'b1, 8'h00, 1'b0);
        chk("cfg0_byte", 128'(cfg_out[7:0]), 128'(8'h3C));
        txn(18'h10, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("cfg0_read_const", 128'(last_rd), 128'(36'h03C3C3C3C));

        txn(18'h00, 8'h00, 1'b0, 8'h12, 1'b0);
        chk("id_read_const", 128'(last_rd), 128'(36'h0A5A5A5A5));
        txn(18'h20, 8'h00, 1'b0, 8'h12, 1'b0);
        chk("oor_err_const", 128'({last_err, last_rd}), 128'({1'b1, 36'h0}));

        txn(18'h11, 8'h55, 1'b1, 8'h00, 1'b1);
        chk("busy_retry_const", 128'(last_rt), 128'(1));
        chk("busy_no_write", 128'(cfg_out[15:8]), 128'(8'h00));

        // Request withdrawn during wait states.
        @(negedge clk);
        umi_req = 1'b1; umi_addr = 18'h12; umi_wdata = 36'h99; umi_wr_n = 1'b1; busy_in = 1'b0;
        @(negedge clk);
        umi_req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (umi_ack) ack_cnt++;
        end
        chk("abort_no_ack", 128'(ack_cnt), 128'(0));
        chk("abort_no_write", cfg_out, model_cfg());
        txn(18'h12, 8'h99, 1'b1, 8'h00, 1'b0);
        chk("after_abort_write", 128'(cfg_out[23:16]), 128'(8'h99));

        // Reset pulse in the middle of a transaction.
        @(negedge clk);
        umi_req = 1'b1; umi_addr = 18'h13; umi_wdata = 36'hEE; umi_wr_n = 1'b1; busy_in = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midreset_outputs", 128'({umi_ack, umi_err, umi_retry, umi_rdata}), 128'(0));
        chk("midreset_cfg", cfg_out, 128'(0));
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        umi_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (umi_ack) ack_cnt++;
        end
        chk("postreset_no_ack", 128'(ack_cnt), 128'(0));
        chk("postreset_cfg", cfg_out, 128'(0));

        // Write to a read-only register, then confirm status readback.
        txn(18'h01, 8'h5A, 1'b1, 8'h33, 1'b0);
        chk("ro_write_err", 128'(last_err), 128'(PROT));
        txn(18'h01, 8'h00, 1'b0, 8'h33, 1'b0);
        chk("stat_readback", 128'(last_rd), 128'(36'h033333333));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) ra = 18'($urandom_range(0, 18'h3FFFF));
            else ra = 18'($urandom_range(0, 47));
            txn(ra, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
